// File: rtl/dual_xor_cfg_deserializer.sv
// Receive end of the dual-XOR cipher config chain: serial LSB-first frame in,
// length-checked atomic commit to the active register. Optional macro: CFG_READBACK_EN.
module dual_xor_cfg_deserializer #(
  parameter int M = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic                        cfg_i,
  output logic                        cfg_o,
  output logic                        mux_ext_a,
  output logic                        mux_en_d,
  output logic [M-1:0]                tx_lfsr_taps,
  output logic [M-1:0]                tx_lfsr_state,
  output logic [M-1:0]                rx_lfsr_taps,
  output logic [M-1:0]                rx_lfsr_state,
  output logic                        cfg_load,
  output logic                        cfg_valid,
  output logic                        cfg_err,
  output logic                        dbg_state,
  output logic [$clog2(4*M+4)-1:0]    dbg_bit_cnt
);

  localparam int CFG_W = 4*M+2;
  localparam int CNT_W = $clog2(CFG_W+2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(CFG_W+1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               load_q, load_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      active_q  <= '0;
      bit_cnt_q <= '0;
      load_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      bit_cnt_q <= bit_cnt_d;
      load_q    <= load_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    bit_cnt_d = bit_cnt_q;
    load_d    = 1'b0;
    valid_d   = valid_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_en) begin
          shadow_d  = {cfg_i, shadow_q[CFG_W-1:1]};
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end else begin
`ifdef CFG_READBACK_EN
          // Preload so the next frame pushes the live config out on cfg_o.
          shadow_d = active_q;
`endif
        end
      end
      SHIFT: begin
        if (cfg_en) begin
          shadow_d  = {cfg_i, shadow_q[CFG_W-1:1]};
          // Saturate at the overrun marker so long frames never wrap to CFG_W.
          bit_cnt_d = (bit_cnt_q == CNT_OVR) ? CNT_OVR : bit_cnt_q + CNT_W'(1);
        end else begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q == CNT_FULL) begin
            active_d = shadow_q;
            load_d   = 1'b1;
            valid_d  = 1'b1;
            err_d    = 1'b0;
          end else begin
            err_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_o         = shadow_q[0];
  assign mux_ext_a     = active_q[4*M+1];
  assign mux_en_d      = active_q[4*M];
  assign tx_lfsr_taps  = active_q[4*M-1:3*M];
  assign tx_lfsr_state = active_q[3*M-1:2*M];
  assign rx_lfsr_taps  = active_q[2*M-1:M];
  assign rx_lfsr_state = active_q[M-1:0];
  assign cfg_load      = load_q;
  assign cfg_valid     = valid_q;
  assign cfg_err       = err_q;
  assign dbg_state     = (state_q == SHIFT);
  assign dbg_bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_dual_xor_cfg_deserializer.sv
// Bench for dual_xor_cfg_deserializer: directed frames plus random frames,
// checked every cycle against a frame-level reference model.
module tb_dual_xor_cfg_deserializer;

  localparam int M     = 32;
  localparam int CFG_W = 4*M+2;
  localparam int CNT_W = $clog2(CFG_W+2);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_en;
  logic              cfg_i;
  logic              cfg_o, mux_ext_a, mux_en_d;
  logic [M-1:0]      tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state;
  logic              cfg_load, cfg_valid, cfg_err;
  logic              dbg_state;
  logic [CNT_W-1:0]  dbg_bit_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int load_cnt = 0;

  // Reference model state
  logic [CFG_W-1:0] m_shadow, m_active;
  int               m_cnt;
  bit               m_in;
  logic             m_load, m_valid, m_err;

  logic [CFG_W-1:0] w_word, nw_word, r_word, exp_seq, cap;
  int               l0;

  dual_xor_cfg_deserializer #(.M(M)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
    .mux_ext_a(mux_ext_a), .mux_en_d(mux_en_d),
    .tx_lfsr_taps(tx_lfsr_taps), .tx_lfsr_state(tx_lfsr_state),
    .rx_lfsr_taps(rx_lfsr_taps), .rx_lfsr_state(rx_lfsr_state),
    .cfg_load(cfg_load), .cfg_valid(cfg_valid), .cfg_err(cfg_err),
    .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CFG_W-1:0] dut_word();
    return {mux_ext_a, mux_en_d, tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state};
  endfunction

  function automatic logic [CFG_W-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[CFG_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_cnt = 0; m_in = 0;
    m_load = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic en, input logic b);
    m_load = 0;
    if (en) begin
      m_shadow = {b, m_shadow[CFG_W-1:1]};
      if (!m_in) begin m_in = 1; m_cnt = 0; end
      m_cnt++;
    end else if (m_in) begin
      m_in = 0;
      if (m_cnt == CFG_W) begin
        m_active = m_shadow; m_load = 1; m_valid = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
`ifdef CFG_READBACK_EN
      m_shadow = m_active;
`endif
    end
  endtask

  task automatic check_all();
    int ec;
    ec = m_in ? ((m_cnt > CFG_W+1) ? CFG_W+1 : m_cnt) : 0;
    chk("cfg_o",     CFG_W'(cfg_o),     CFG_W'(m_shadow[0]));
    chk("cfg_load",  CFG_W'(cfg_load),  CFG_W'(m_load));
    chk("cfg_valid", CFG_W'(cfg_valid), CFG_W'(m_valid));
    chk("cfg_err",   CFG_W'(cfg_err),   CFG_W'(m_err));
    chk("state",     CFG_W'(dbg_state), CFG_W'(m_in));
    chk("bit_cnt",   CFG_W'(dbg_bit_cnt), CFG_W'(ec));
    chk("active",    dut_word(),        m_active);
  endtask

  task automatic step(input logic en, input logic b);
    cfg_en = en;
    cfg_i  = b;
    @(posedge clk);
    #1;
    if (cfg_load) load_cnt++;
    model_edge(en, b);
    check_all();
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++)
      step(1'b1, (i < CFG_W) ? w[i] : 1'($urandom_range(0, 1)));
    for (int g = 0; g < gap; g++)
      step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic async_reset();
    #2;
    cfg_en = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    w_word  = {1'b0, 1'b0, 32'h48000000, 32'h77000000, 32'h48000000, 32'h77000000};
    nw_word = ~w_word;
    rst = 1'b1; cfg_en = 1'b0; cfg_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // 1: good frame W
    l0 = load_cnt;
    send_frame(w_word, CFG_W, 1);
    chk("t1_load_now", CFG_W'(cfg_load), CFG_W'(1));
    step(1'b0, 1'b0);
    chk("t1_loads", CFG_W'(load_cnt - l0), CFG_W'(1));
    chk("t1_word", dut_word(), w_word);
    chk("t1_tx_taps", CFG_W'(tx_lfsr_taps), CFG_W'(32'h48000000));
    chk("t1_rx_state", CFG_W'(rx_lfsr_state), CFG_W'(32'h77000000));
    chk("t1_valid", CFG_W'(cfg_valid), CFG_W'(1));
    chk("t1_err", CFG_W'(cfg_err), CFG_W'(0));

    // 2: short frame then good ~W
    l0 = load_cnt;
    send_frame(rand_word(), CFG_W-1, 2);
    chk("t2_err", CFG_W'(cfg_err), CFG_W'(1));
    chk("t2_loads", CFG_W'(load_cnt - l0), CFG_W'(0));
    chk("t2_word", dut_word(), w_word);
    send_frame(nw_word, CFG_W, 2);
    chk("t2_word_nw", dut_word(), nw_word);
    chk("t2_err_clr", CFG_W'(cfg_err), CFG_W'(0));

    // 3: overrun, counter saturates
    send_frame(rand_word(), CFG_W+1, 0);
    chk("t3_cnt_131", CFG_W'(dbg_bit_cnt), CFG_W'(CFG_W+1));
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("t3_cnt_sat", CFG_W'(dbg_bit_cnt), CFG_W'(CFG_W+1));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t3_err", CFG_W'(cfg_err), CFG_W'(1));
    chk("t3_word", dut_word(), nw_word);

    // 4: back-to-back with one idle cycle
    l0 = load_cnt;
    send_frame(w_word, CFG_W, 1);
    send_frame(nw_word, CFG_W, 2);
    chk("t4_loads", CFG_W'(load_cnt - l0), CFG_W'(2));
    chk("t4_word", dut_word(), nw_word);

    // 5: async reset mid-frame
    send_frame(w_word, 64, 0);
    async_reset();
    chk("t5_word0", dut_word(), '0);
    chk("t5_valid0", CFG_W'(cfg_valid), CFG_W'(0));
    send_frame(w_word, CFG_W, 2);
    chk("t5_word", dut_word(), w_word);
    chk("t5_valid", CFG_W'(cfg_valid), CFG_W'(1));

    // 6: cfg_o sequence while shifting ~W after a rejected frame
    r_word = rand_word();
    send_frame(r_word, CFG_W-1, 3);
`ifdef CFG_READBACK_EN
    exp_seq = w_word;
`else
    exp_seq = {r_word[CFG_W-2:0], w_word[CFG_W-1]};
`endif
    for (int i = 0; i < CFG_W; i++) begin
      cap[i] = cfg_o;
      step(1'b1, nw_word[i]);
    end
    chk("t6_cfg_o_seq", cap, exp_seq);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t6_word", dut_word(), nw_word);

    // Random frames of assorted lengths and gaps
    for (int k = 0; k < 20; k++) begin
      int len;
      case ($urandom_range(0, 4))
        0: len = CFG_W - 1;
        1: len = CFG_W + 1;
        2: len = $urandom_range(1, CFG_W + 10);
        default: len = CFG_W;
      endcase
      send_frame(rand_word(), len, $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
